// File: rtl/r5p_bus_arb_if.sv
// rtl/r5p_bus_arb_if.sv - r5p_bus_if request/response bus shared by managers and subordinates
// Purpose: one bus port carrying a request (vld,wen,adr,ben,wdt) and its handshake/response (rdy,rdt).
// Ports:   man modport drives the request and reads rdy/rdt; sub modport is the mirror image.
interface r5p_bus_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned BW = DW / 8;

  logic          vld;
  logic          wen;
  logic [AW-1:0] adr;
  logic [BW-1:0] ben;
  logic [DW-1:0] wdt;
  logic [DW-1:0] rdt;
  logic          rdy;

  modport man (output vld, wen, adr, ben, wdt, input rdt, rdy);
  modport sub (input vld, wen, adr, ben, wdt, output rdt, rdy);
endinterface

// File: rtl/r5p_bus_arb.sv
// rtl/r5p_bus_arb.sv - 2:1 arbiter merging fetch and load/store managers onto one bus
// Purpose: combinational grant/mux of two managers onto a fixed-latency subordinate, with a
//          LAT-deep tracker that steers each read response back to the manager that issued it.
// Ports:   clk, rst (synchronous, active-high)
//          s_if - instruction-fetch manager (sub side), s_ls - load/store manager (sub side)
//          m    - merged port toward the subordinate (man side)
module r5p_bus_arb #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 1,
  parameter string       PRI = "RR"
) (
  input  logic   clk,
  input  logic   rst,
  r5p_bus_if.sub s_if,
  r5p_bus_if.sub s_ls,
  r5p_bus_if.man m
);
  localparam int unsigned BW     = DW / 8;
  localparam bit          PRI_LS = (PRI == "LS");

  logic           gnt;      // granted index: 0 = s_if, 1 = s_ls
  logic           xfer;
  logic           wen_mux;
  logic [AW-1:0]  adr_mux;
  logic [BW-1:0]  ben_mux;
  logic [DW-1:0]  wdt_mux;
  logic           ptr_q, ptr_d;
  logic [LAT-1:0] act_q, act_d;
  logic [LAT-1:0] own_q, own_d;
  logic           rsp_act;
  logic           rsp_own;

  // With nobody requesting the grant falls to s_if so the idle bus carries s_if's fields.
  always_comb begin
    gnt = 1'b0;
    if (s_ls.vld) begin
      if (!s_if.vld || PRI_LS) gnt = 1'b1;
      else                     gnt = ptr_q;
    end
  end

  always_comb begin
    if (gnt) begin
      wen_mux = s_ls.wen;
      adr_mux = s_ls.adr;
      ben_mux = s_ls.ben;
      wdt_mux = s_ls.wdt;
    end else begin
      wen_mux = s_if.wen;
      adr_mux = s_if.adr;
      ben_mux = s_if.ben;
      wdt_mux = s_if.wdt;
    end
  end

  assign m.vld = s_if.vld | s_ls.vld;
  assign m.wen = wen_mux;
  assign m.adr = adr_mux;
  assign m.ben = ben_mux;
  assign m.wdt = wdt_mux;

  // Gating with vld keeps both rdy low on an idle bus even though s_if holds the default grant.
  assign s_if.rdy = m.rdy & s_if.vld & ~gnt;
  assign s_ls.rdy = m.rdy & s_ls.vld & gnt;

  assign xfer = m.vld & m.rdy;

  // Tracker entry 0 is the transfer happening now; the last entry lines up with the
  // subordinate's rdt, so each read is routed by its own entry even when owners alternate.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && !PRI_LS) ptr_d = ~gnt;
    act_d    = act_q;
    own_d    = own_q;
    act_d[0] = xfer & ~wen_mux;
    own_d[0] = gnt;
    for (int i = 1; i < LAT; i++) begin
      act_d[i] = act_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
      act_q <= '0;
      own_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      act_q <= act_d;
      own_q <= own_d;
    end
  end

  assign rsp_act = act_q[LAT-1];
  assign rsp_own = own_q[LAT-1];

  // Outside its own response cycle a manager sees X, which flushes out early sampling in sim.
  assign s_if.rdt = (rsp_act && !rsp_own) ? m.rdt : {DW{1'bx}};
  assign s_ls.rdt = (rsp_act &&  rsp_own) ? m.rdt : {DW{1'bx}};

  a_if_no_write: assert property (@(posedge clk) disable iff (rst) s_if.vld |-> !s_if.wen);
  a_if_hold: assert property (@(posedge clk) disable iff (rst)
    (s_if.vld && !s_if.rdy) |=> (s_if.vld && $stable(s_if.adr) && $stable(s_if.ben) && $stable(s_if.wdt)));
  a_ls_hold: assert property (@(posedge clk) disable iff (rst)
    (s_ls.vld && !s_ls.rdy) |=> (s_ls.vld && $stable(s_ls.wen) && $stable(s_ls.adr)
                                 && $stable(s_ls.ben) && $stable(s_ls.wdt)));
endmodule
